cache_mem_responder: RTL and testbench

- Memory-side responder for the cache's refill/writeback interface: accepts rd_req/wr_req from the cache, serves them from an internal word-addressed RAM, and returns read data as 1-beat or 4-beat bursts with ret_valid/ret_last.
- Serves as the standalone memory model for cache unit benches and as the SoC-less backing store in the small FPGA build.
- Sits directly below the cache, one instance per cache port.

---
 rtl/cache_bus_pkg.sv | 34 +++
 rtl/cache_mem_responder_resp_ram.sv | 32 +++
 rtl/cache_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_cache_mem_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared cache bus types, line geometry and read FSM encoding
package cache_bus_pkg;

  // Request type codes; any code other than RT_LINE is served as a single word
  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_WORD = 3'b010;
  localparam logic [2:0] RT_LINE = 3'b100;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;

  // One-hot read FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_WAIT  = 3'b010,
    ST_BURST = 3'b100
  } rd_state_e;

  // Overlay the strobed bytes of new_line onto old_line
  function automatic logic [LINE_BITS-1:0] merge_line(
    input logic [LINE_BITS-1:0]   old_line,
    input logic [LINE_BITS-1:0]   new_line,
    input logic [LINE_BITS/8-1:0] be
  );
    logic [LINE_BITS-1:0] res;
    res = old_line;
    for (int i = 0; i < LINE_BITS/8; i++) begin
      if (be[i]) res[8*i +: 8] = new_line[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_mem_responder_resp_ram.sv
// rtl/cache_mem_responder_resp_ram.sv - 4-bank word RAM with 128-bit line read and byte-strobed write
// Bank b holds word b of every line (bank = byte addr[3:2]), so a whole line
// is read or written in one cycle. Contents are not touched by reset.
module resp_ram
  import cache_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic [ADDR_WIDTH-3:0]   rd_line_i,
  output logic [LINE_BITS-1:0]    rd_data_o,
  input  logic [ADDR_WIDTH-3:0]   wr_line_i,
  input  logic [LINE_BITS/8-1:0]  wr_be_i,
  input  logic [LINE_BITS-1:0]    wr_data_i
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  for (genvar b = 0; b < LINE_WORDS; b++) begin : g_bank
    logic [31:0] mem_q [DEPTH];

    // Byte-strobed write into this bank's word of the addressed line
    always_ff @(posedge clk) begin
      for (int y = 0; y < 4; y++) begin
        if (wr_be_i[4*b + y]) mem_q[wr_line_i][8*y +: 8] <= wr_data_i[32*b + 8*y +: 8];
      end
    end

    assign rd_data_o[32*b +: 32] = mem_q[rd_line_i];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - memory-side refill/writeback responder for the cache (optional CACHE_RESP_RANDOM_STALL_EN)
// CACHE_RESP_RANDOM_STALL_EN: a 16-bit LFSR (seed 16'hACE1) stalls rd_rdy,
// wr_rdy and inserts bubbles into read bursts.
module cache_mem_responder
  import cache_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [2:0]           rd_type,
  input  logic [31:0]          rd_addr,
  output logic                 rd_rdy,
  output logic                 ret_valid,
  output logic                 ret_last,
  output logic [31:0]          ret_data,
  input  logic                 wr_req,
  input  logic [2:0]           wr_type,
  input  logic [31:0]          wr_addr,
  input  logic [3:0]           wr_wstrb,
  input  logic [LINE_BITS-1:0] wr_data,
  output logic                 wr_rdy
);

  localparam int LW = ADDR_WIDTH - 2;

  logic rd_stall, wr_stall, beat_stall;

`ifdef CACHE_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR, x^16+x^14+x^13+x^11+1
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR reloads its seed on reset and steps every cycle
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign rd_stall   = lfsr_q[0];
  assign wr_stall   = lfsr_q[1];
  assign beat_stall = lfsr_q[2];
`else
  assign rd_stall   = 1'b0;
  assign wr_stall   = 1'b0;
  assign beat_stall = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:ADDR_WIDTH+2], rd_addr[1:0],
                              wr_addr[31:ADDR_WIDTH+2], wr_addr[1:0]};

  logic                   wr_acc;
  logic [LW-1:0]          wr_line, rd_line;
  logic [LINE_BITS/8-1:0] wr_be;
  logic [LINE_BITS-1:0]   wr_line_data, ram_rd_data, snap;

  // A write coinciding with reset is dropped
  assign wr_rdy  = !wr_stall;
  assign wr_acc  = wr_req && wr_rdy && !reset;
  assign wr_line = wr_addr[ADDR_WIDTH+1:4];
  assign rd_line = rd_addr[ADDR_WIDTH+1:4];

  // Turn the write request into line-wide byte enables and data
  always_comb begin
    wr_be        = '0;
    wr_line_data = {LINE_WORDS{wr_data[31:0]}};
    if (wr_type == RT_LINE) begin
      wr_be        = '1;
      wr_line_data = wr_data;
    end else begin
      wr_be = {12'b0, wr_wstrb} << {wr_addr[3:2], 2'b00};
    end
    if (!wr_acc) wr_be = '0;
  end

  resp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk       (clk),
    .rd_line_i (rd_line),
    .rd_data_o (ram_rd_data),
    .wr_line_i (wr_line),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_line_data)
  );

  // Line snapshot with a same-cycle write to the same line forwarded in
  always_comb begin
    snap = ram_rd_data;
    if (wr_line == rd_line) snap = merge_line(ram_rd_data, wr_line_data, wr_be);
  end

  rd_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2:0]           beats_q, beats_d;
  logic [1:0]           idx_q, idx_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  // Read FSM next state and outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    idx_d     = idx_q;
    line_d    = line_q;
    rd_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    case (state_q)
      ST_IDLE: begin
        rd_rdy = !rd_stall;
        if (rd_req && !rd_stall) begin
          line_d = snap;
          if (rd_type == RT_LINE) begin
            beats_d = 3'd4;
            idx_d   = 2'd0;
          end else begin
            beats_d = 3'd1;
            idx_d   = rd_addr[3:2];
          end
          cnt_d   = 4'(RD_LATENCY - 1);
          state_d = (RD_LATENCY == 1) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (!beat_stall) begin
          ret_valid = 1'b1;
          ret_data  = line_q[{idx_q, 5'b00000} +: 32];
          ret_last  = (beats_q == 3'd1);
          idx_d     = idx_q + 2'd1;
          beats_d   = beats_q - 3'd1;
          if (beats_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      idx_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - self-checking bench for cache_mem_responder
module tb_cache_mem_responder;

  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset, rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr, ret_data;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;

  always #5 clk = ~clk;

  cache_mem_responder #(.ADDR_WIDTH(12), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem_m [4096];
  int busy_until = -1, rd_start = 0, rd_nb = 0, acc_cyc = 0;
  logic [31:0] rd_beats [4];
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int line_word(input logic [31:0] a, input int i);
    return int'((((a >> 4) * 32'd4) + 32'(i)) % 32'd4096);
  endfunction

  task automatic model_write();
    int w;
    if (wr_type == 3'b100) begin
      for (int i = 0; i < 4; i++) mem_m[line_word(wr_addr, i)] = wr_data[32*i +: 32];
    end else begin
      w = int'((wr_addr >> 2) % 32'd4096);
      for (int b = 0; b < 4; b++) if (wr_wstrb[b]) mem_m[w][8*b +: 8] = wr_data[8*b +: 8];
    end
  endtask

  // What the upcoming clock edge does, given the inputs currently driven
  task automatic model_edge();
    if (reset) begin
      busy_until = cyc;
      rd_nb = 0;
    end else begin
      if (wr_req) model_write();
      if (rd_req && cyc > busy_until) begin
        rd_nb = (rd_type == 3'b100) ? 4 : 1;
        for (int i = 0; i < rd_nb; i++)
          rd_beats[i] = (rd_nb == 4) ? mem_m[line_word(rd_addr, i)]
                                     : mem_m[int'((rd_addr >> 2) % 32'd4096)];
        rd_start   = cyc + L;
        busy_until = rd_start + rd_nb - 1;
        acc_cyc    = cyc;
      end
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (cyc >= rd_start) && (cyc < rd_start + rd_nb);
    chk1("rd_rdy", rd_rdy, cyc > busy_until);
    chk1("wr_rdy", wr_rdy, 1'b1);
    chk1("ret_valid", ret_valid, ev);
    if (ev) begin
      chk("ret_data", ret_data, rd_beats[cyc - rd_start]);
      chk1("ret_last", ret_last, cyc == rd_start + rd_nb - 1);
    end else begin
      chk1("ret_last_idle", ret_last, 1'b0);
    end
    if (ret_valid === 1'b1) begin
      got_d.push_back(ret_data);
      got_l.push_back(ret_last);
      got_c.push_back(cyc);
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic wr(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                    input logic [127:0] d);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    clear_got();
    rd_req = 1'b1; rd_type = 3'b010; rd_addr = a;
    tick();
    rd_req = 1'b0;
    ticks(L + 3);
    chk({tag, "_beats"}, 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) begin
      chk({tag, "_data"}, got_d[0], exp);
      chk1({tag, "_last"}, got_l[0], 1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_m[i] = '0;
    reset = 1'b1; rd_req = 1'b0; rd_type = 3'b010; rd_addr = '0;
    wr_req = 1'b0; wr_type = 3'b010; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    ticks(2);
    chk1("reset_rd_rdy", rd_rdy, 1'b1);
    chk1("reset_wr_rdy", wr_rdy, 1'b1);
    chk1("reset_ret_valid", ret_valid, 1'b0);
    chk1("reset_ret_last", ret_last, 1'b0);
    chk("reset_ret_data", ret_data, 32'h0);
    reset = 1'b0;

    // Give every line used below known contents
    for (int a = 0; a < 256; a += 16) wr(3'b100, 32'(a), 4'h0, '0);
    wr(3'b100, 32'h200, 4'h0, '0);

    // Line write then line read from inside the line
    wr(3'b100, 32'h0000_1230, 4'h0, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
    clear_got();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_1234;
    tick();
    rd_req = 1'b0;
    ticks(6);
    chk("line_beats", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      chk("line_b0", got_d[0], 32'hAAAA_AAAA);
      chk("line_b1", got_d[1], 32'hBBBB_BBBB);
      chk("line_b2", got_d[2], 32'hCCCC_CCCC);
      chk("line_b3", got_d[3], 32'hDDDD_DDDD);
      chk1("line_l2", got_l[2], 1'b0);
      chk1("line_l3", got_l[3], 1'b1);
      chk("line_latency", 32'(got_c[0] - acc_cyc), 32'(L));
      chk("line_span", 32'(got_c[3] - got_c[0]), 32'd3);
    end

    // Strobed word write and word read
    wr(3'b010, 32'h40, 4'b0101, {96'h0, 32'h1122_3344});
    rd_word("word40", 32'h40, 32'h0022_0044);

    // Same-cycle write forwarded, later write not visible
    wr(3'b010, 32'h20C, 4'hF, {96'h0, 32'h0C0C_0C0C});
    clear_got();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h208;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h208; wr_wstrb = 4'hF; wr_data = {96'h0, 32'hFEED_BEEF};
    tick();
    rd_req = 1'b0;
    wr_addr = 32'h20C; wr_data = {96'h0, 32'h1234_5678};
    tick();
    wr_req = 1'b0;
    ticks(5);
    chk("fwd_beats", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      chk("fwd_b2", got_d[2], 32'hFEED_BEEF);
      chk("fwd_b3_old", got_d[3], 32'h0C0C_0C0C);
    end

    // Held request: second read accepted right after ret_last
    clear_got();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1230;
    ticks(7);
    rd_req = 1'b0;
    ticks(8);
    chk("held_beats", 32'(got_d.size()), 32'd8);
    if (got_d.size() == 8) begin
      chk("held_b4", got_d[4], 32'hAAAA_AAAA);
      chk("held_b7", got_d[7], 32'hDDDD_DDDD);
      chk1("held_l3", got_l[3], 1'b1);
      chk("held_gap", 32'(got_c[4] - got_c[3]), 32'd3);
    end

    // Reset after beat 2; a write on the reset edge is dropped
    clear_got();
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h1230;
    tick();
    rd_req = 1'b0;
    ticks(2);
    reset = 1'b1;
    wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h40; wr_wstrb = 4'hF; wr_data = {96'h0, 32'hFFFF_FFFF};
    tick();
    reset = 1'b0; wr_req = 1'b0;
    chk1("rst_mid_valid", ret_valid, 1'b0);
    chk1("rst_mid_rdy", rd_rdy, 1'b1);
    chk("rst_mid_beats", 32'(got_d.size()), 32'd2);
    rd_word("after_rst", 32'h1238, 32'hCCCC_CCCC);
    rd_word("rst_wr_drop", 32'h40, 32'h0022_0044);
    rd_word("alias", 32'h0001_0040, 32'h0022_0044);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      rd_req   = ($urandom_range(0, 2) == 0);
      rd_type  = 3'($urandom_range(0, 7));
      rd_addr  = $urandom & 32'h0001_00FF;
      wr_req   = ($urandom_range(0, 1) == 0);
      wr_type  = ($urandom_range(0, 3) == 0) ? 3'b100 : 3'($urandom_range(0, 7));
      wr_addr  = $urandom & 32'h0001_00FF;
      wr_wstrb = 4'($urandom_range(0, 15));
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    ticks(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
